// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic result drain: state encoding, default
// geometry and the width helper used to size index and counter registers.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        STREAM  = 2'd2
    } state_t;

    localparam int DEF_WIDTH_SUM = 8;
    localparam int DEF_ROW       = 3;
    localparam int DEF_COLOUM    = 3;
    localparam int DEF_LATENCY   = 8;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_ELEM = DEF_ROW * DEF_COLOUM;
    localparam int IDX_W  = idx_width(N_ELEM);
    localparam int CNT_W  = idx_width(DEF_LATENCY);

endpackage

// File: rtl/systolic_result_drain.sv
// Runs the systolic array for LATENCY cycles, snapshots its C results and
// overflow flag, then streams the matrix out row-major over VALID/READY.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int WIDTH_SUM = DEF_WIDTH_SUM,
    parameter int ROW       = DEF_ROW,
    parameter int COLOUM    = DEF_COLOUM,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            START,
    input  logic [ROW*COLOUM*WIDTH_SUM-1:0] C_IN,
    input  logic                            MULTI_OVER_IN,
    output logic                            ARRAY_ENABLE,
    output logic                            BUSY,
    output logic                            OUT_VALID,
    input  logic                            OUT_READY,
    output logic [WIDTH_SUM-1:0]            OUT_DATA,
    output logic [idx_width(ROW)-1:0]       OUT_ROW,
    output logic [idx_width(COLOUM)-1:0]    OUT_COL,
    output logic                            OUT_LAST,
    output logic                            OUT_OVER,
    output logic                            DONE
);

    localparam int N    = ROW * COLOUM;
    localparam int IW   = idx_width(N);
    localparam int CW   = idx_width(LATENCY);
    localparam int RW   = idx_width(ROW);
    localparam int COLW = idx_width(COLOUM);

    state_t                      state, state_next;
    logic [CW-1:0]               cnt;
    logic                        sticky;
    logic                        over;
    logic [N*WIDTH_SUM-1:0]      snap;
    logic [IW-1:0]               idx;
    logic [RW-1:0]               row;
    logic [COLW-1:0]             col;
    logic                        done;
    logic [WIDTH_SUM-1:0]        elem [N];

    logic capture;
    logic last;
    logic accept;

    assign capture = (state == COMPUTE) && (cnt == CW'(LATENCY - 1));
    assign last    = (idx == IW'(N - 1));
    assign accept  = (state == STREAM) && OUT_READY;

    for (genvar g = 0; g < N; g++) begin : g_elem
        assign elem[g] = snap[g*WIDTH_SUM +: WIDTH_SUM];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (START)           state_next = COMPUTE;
            COMPUTE: if (capture)         state_next = STREAM;
            STREAM:  if (accept && last)  state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // NOTE: the snapshot is cleared by reset as well, so an aborted matrix can
    // never leak stale data onto OUT_DATA.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt    <= '0;
            sticky <= 1'b0;
            over   <= 1'b0;
            snap   <= '0;
            idx    <= '0;
            row    <= '0;
            col    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        cnt    <= '0;
                        sticky <= 1'b0;
                    end
                end
                COMPUTE: begin
                    cnt    <= cnt + CW'(1);
                    sticky <= sticky | MULTI_OVER_IN;
                    if (capture) begin
                        snap <= C_IN;
                        over <= sticky | MULTI_OVER_IN;
                        idx  <= '0;
                        row  <= '0;
                        col  <= '0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (last) begin
                            done <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                            // Row/column tracked incrementally instead of dividing idx.
                            if (col == COLW'(COLOUM - 1)) begin
                                col <= '0;
                                row <= row + RW'(1);
                            end else begin
                                col <= col + COLW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ARRAY_ENABLE = (state == COMPUTE);
    assign BUSY         = (state != IDLE);
    assign OUT_VALID    = (state == STREAM);
    assign OUT_LAST     = OUT_VALID && last;
    assign OUT_DATA     = OUT_VALID ? elem[idx] : '0;
    assign OUT_ROW      = OUT_VALID ? row : '0;
    assign OUT_COL      = OUT_VALID ? col : '0;
    assign OUT_OVER     = over;
    assign DONE         = done;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_systolic_result_drain;

    localparam int W   = 8;
    localparam int LAT = 8;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] row;
        logic [1:0] col;
        logic       last;
        logic       over;
    } beat_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [71:0] C_IN;
    logic        MULTI_OVER_IN;
    logic        ARRAY_ENABLE;
    logic        BUSY;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [7:0]  OUT_DATA;
    logic [1:0]  OUT_ROW;
    logic [1:0]  OUT_COL;
    logic        OUT_LAST;
    logic        OUT_OVER;
    logic        DONE;

    systolic_result_drain #(
        .WIDTH_SUM(W), .ROW(3), .COLOUM(3), .LATENCY(LAT)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .C_IN(C_IN),
        .MULTI_OVER_IN(MULTI_OVER_IN), .ARRAY_ENABLE(ARRAY_ENABLE),
        .BUSY(BUSY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_DATA(OUT_DATA), .OUT_ROW(OUT_ROW), .OUT_COL(OUT_COL),
        .OUT_LAST(OUT_LAST), .OUT_OVER(OUT_OVER), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    bit    timed = 1'b0;
    int    beats = 0;
    int    done_cnt = 0;
    int    en_len = 0;
    beat_t exp_q [$];
    bit    stall_prev = 1'b0;
    beat_t prev_beat;

    logic [7:0] v_basic [9];
    logic [7:0] v_bp    [9];
    logic [7:0] v_ov    [9];
    logic [7:0] v_iso   [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [17:0] all_outputs();
        return {ARRAY_ENABLE, BUSY, OUT_VALID, OUT_DATA, OUT_ROW, OUT_COL,
                OUT_LAST, OUT_OVER, DONE};
    endfunction

    always @(posedge CLK) cyc++;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        beat_t cur;
        cur = '{data: OUT_DATA, row: OUT_ROW, col: OUT_COL, last: OUT_LAST, over: OUT_OVER};
        if (!RST) begin
            stall_prev = 1'b0;
            en_len     = 0;
        end else begin
            if (ARRAY_ENABLE) begin
                en_len++;
            end else if (en_len != 0) begin
                check("enable_len", en_len, LAT);
                en_len = 0;
            end
            if (stall_prev && OUT_VALID)
                check("stall_hold", cur, prev_beat);
            if (OUT_VALID) begin
                if (OUT_READY) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_beat: got %0h expected none at cycle %0d", cur, cyc);
                    end else begin
                        check("beat", cur, exp_q.pop_front());
                    end
                    beats++;
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    prev_beat  = cur;
                end
            end else begin
                stall_prev = 1'b0;
            end
            if (DONE) begin
                done_cnt++;
                check("done_after_last", exp_q.size(), 0);
                if (timed) check("done_latency", cyc - start_cyc, 18);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_run(input logic [7:0] v [9], input int pulse_at,
                             input bit over_exp, input bit time_it);
        for (int i = 0; i < 9; i++) begin
            C_IN[i*8 +: 8] = v[i];
            exp_q.push_back('{data: v[i], row: 2'(i / 3), col: 2'(i % 3),
                              last: (i == 8), over: over_exp});
        end
        beats     = 0;
        timed     = time_it;
        start_cyc = cyc;
        START     = 1'b1;
        tick();
        START = 1'b0;
        if (pulse_at >= 0) begin
            repeat (pulse_at) tick();
            MULTI_OVER_IN = 1'b1;
            tick();
            MULTI_OVER_IN = 1'b0;
        end
    endtask

    // mode 0: ready held high; 1: 5-cycle stall on beat 4 then toggling;
    // 2: ready high and C_IN forced to 0xFF once streaming has begun.
    task automatic run_wait(input int mode, input int target);
        int stall = 0;
        for (int k = 0; k < 200 && done_cnt < target; k++) begin
            case (mode)
                1: begin
                    if (beats == 3 && OUT_VALID && stall < 5) begin
                        OUT_READY = 1'b0;
                        stall++;
                    end else if (beats >= 3 && stall >= 5) begin
                        OUT_READY = ~OUT_READY;
                    end else begin
                        OUT_READY = 1'b1;
                    end
                end
                2: begin
                    OUT_READY = 1'b1;
                    if (OUT_VALID) C_IN = '1;
                end
                default: OUT_READY = 1'b1;
            endcase
            tick();
        end
        OUT_READY = 1'b1;
        check("done_count", done_cnt, target);
        check("beats", beats, 9);
        tick();
        check("idle_after", {ARRAY_ENABLE, BUSY, OUT_VALID, DONE}, 4'b0);
    endtask

    initial begin
        v_basic = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        v_bp    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        v_ov    = '{8'hF0, 8'h0F, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h55, 8'hAA, 8'h00};
        v_iso   = '{8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

        RST = 1'b0; START = 1'b0; MULTI_OVER_IN = 1'b0; OUT_READY = 1'b0; C_IN = '0;

        // Reset held: wiggle inputs, outputs must stay at zero.
        for (int i = 0; i < 6; i++) begin
            START     = 1'($urandom_range(0, 1));
            OUT_READY = ~OUT_READY;
            tick();
            check("reset_outputs", all_outputs(), 18'h0);
        end
        START = 1'b0; OUT_READY = 1'b1;
        RST   = 1'b1;
        tick();
        check("idle_outputs", all_outputs(), 18'h0);

        // Basic stream, timed.
        start_run(v_basic, -1, 1'b0, 1'b1);
        run_wait(0, 1);

        // Backpressure.
        start_run(v_bp, -1, 1'b0, 1'b0);
        run_wait(1, 2);

        // Overflow pulse at counter 3, then a clean run.
        start_run(v_ov, 3, 1'b1, 1'b0);
        run_wait(0, 3);
        start_run(v_ov, -1, 1'b0, 1'b1);
        run_wait(0, 4);

        // Snapshot isolation.
        start_run(v_iso, -1, 1'b0, 1'b0);
        run_wait(2, 5);

        // Extra STARTs while busy, then reset during beat 5.
        start_run(v_basic, -1, 1'b0, 1'b0);
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 0; k < 100 && beats < 4; k++) begin
            if (beats == 2) START = 1'b1;
            tick();
            START = 1'b0;
        end
        check("reached_beat5", beats, 4);
        RST = 1'b0;
        #1;
        check("async_reset_outputs", all_outputs(), 18'h0);
        exp_q.delete();
        tick();
        check("reset_hold_outputs", all_outputs(), 18'h0);
        RST = 1'b1;
        repeat (25) tick();
        check("no_done_after_reset", done_cnt, 5);
        check("no_beats_after_reset", beats, 4);
        check("idle_after_reset", all_outputs(), 18'h0);

        // Clean full run after the aborted one.
        start_run(v_bp, -1, 1'b0, 1'b1);
        run_wait(0, 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
